// File: rtl/seg_fun_pkg.sv
// Shared constants and mode encoding for the 7-segment FUN display animation/speed control.
package seg_fun_pkg;

  localparam int ANI_BIT       = 6;
  localparam int COUNTER_BIT   = 25;
  localparam int LOOPS_PER_ANI = 4;
  localparam int HOLD_LOOPS    = 8;
  localparam int LOOP_BIT      = $clog2(HOLD_LOOPS);

  localparam logic [ANI_BIT-1:0]     ANI_MAX  = ANI_BIT'(63);
  localparam logic [COUNTER_BIT-1:0] COM_RST  = COUNTER_BIT'(10_000_000);
  localparam logic [COUNTER_BIT-1:0] COM_MIN  = COUNTER_BIT'(1_000_000);
  localparam logic [COUNTER_BIT-1:0] COM_MAX  = COUNTER_BIT'(20_000_000);
  localparam logic [COUNTER_BIT-1:0] COM_STEP = COUNTER_BIT'(1_000_000);

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_HOLD   = 2'd2
  } mode_t;

endpackage

// File: rtl/btn_edge.sv
// Turns a debounced request level into single-cycle step pulses; optional hold-to-repeat timer
// when REPEAT_CYCLES > 1 (the top only enables it under ANI_SCHED_REPEAT_EN).
module btn_edge #(
  parameter int REPEAT_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic step
);

  logic req_q;
  logic rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) req_q <= 1'b0;
    else       req_q <= req;
  end

  assign rise = req & ~req_q;

  generate
    if (REPEAT_CYCLES > 1) begin : g_rep
      localparam int RW = $clog2(REPEAT_CYCLES);
      localparam logic [RW-1:0] LAST = RW'(REPEAT_CYCLES - 1);
      logic [RW-1:0] cnt;
      logic          again;

      // cnt holds the number of held edges since the last step, minus one
      assign again = req & req_q & (cnt == LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset)                     cnt <= '0;
        else if (!req || rise || again) cnt <= '0;
        else                           cnt <= cnt + 1'b1;
      end

      assign step = rise | again;
    end else begin : g_norep
      assign step = rise;
    end
  endgenerate

endmodule

// File: rtl/ani_scheduler.sv
// Animation/speed scheduler: manual button steps, demo-mode auto-advance, speed compare saturation.
// Optional macro ANI_SCHED_REPEAT_EN adds hold-to-repeat on the speed requests.
module ani_scheduler
  import seg_fun_pkg::*;
`ifdef ANI_SCHED_REPEAT_EN
#(
  parameter int REPEAT_CYCLES = 2_500_000
)
`endif
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_ani_inc,
  input  logic                   req_ani_dec,
  input  logic                   req_spd_inc,
  input  logic                   req_spd_dec,
  input  logic                   auto_en,
  input  logic                   digit_wrap,
  output logic [ANI_BIT-1:0]     animation,
  output logic [COUNTER_BIT-1:0] compare,
  output logic                   ani_change,
  output logic [1:0]             mode
);

`ifdef ANI_SCHED_REPEAT_EN
  localparam int SPD_REPEAT = REPEAT_CYCLES;
`else
  localparam int SPD_REPEAT = 0;
`endif

  logic ani_inc_s, ani_dec_s, spd_inc_s, spd_dec_s;

  btn_edge #(.REPEAT_CYCLES(0))          u_ani_inc (.clk(clk), .reset(reset), .req(req_ani_inc), .step(ani_inc_s));
  btn_edge #(.REPEAT_CYCLES(0))          u_ani_dec (.clk(clk), .reset(reset), .req(req_ani_dec), .step(ani_dec_s));
  btn_edge #(.REPEAT_CYCLES(SPD_REPEAT)) u_spd_inc (.clk(clk), .reset(reset), .req(req_spd_inc), .step(spd_inc_s));
  btn_edge #(.REPEAT_CYCLES(SPD_REPEAT)) u_spd_dec (.clk(clk), .reset(reset), .req(req_spd_dec), .step(spd_dec_s));

  function automatic logic [ANI_BIT-1:0] ani_up(input logic [ANI_BIT-1:0] a);
    return (a == ANI_MAX) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [ANI_BIT-1:0] ani_dn(input logic [ANI_BIT-1:0] a);
    return (a == '0) ? ANI_MAX : a - 1'b1;
  endfunction

  // Saturating speed step; inc wins over dec
  function automatic logic [COUNTER_BIT-1:0] spd_next(input logic [COUNTER_BIT-1:0] com,
                                                      input logic up, input logic dn);
    logic [COUNTER_BIT-1:0] r;
    r = com;
    if (up) begin
      if (com <= COM_MAX - COM_STEP) r = com + COM_STEP;
    end else if (dn) begin
      if (com >= COM_MIN + COM_STEP) r = com - COM_STEP;
    end
    return r;
  endfunction

  mode_t                  state, state_nx;
  logic [LOOP_BIT-1:0]    loop_cnt, loop_nx;
  logic [ANI_BIT-1:0]     ani_nx;
  logic                   ani_upd;
  logic                   manual;

  assign manual = ani_inc_s | ani_dec_s;

  always_comb begin
    state_nx = state;
    loop_nx  = loop_cnt;
    ani_nx   = animation;
    ani_upd  = 1'b0;

    if (ani_inc_s) begin
      ani_nx  = ani_up(animation);
      ani_upd = 1'b1;
    end else if (ani_dec_s) begin
      ani_nx  = ani_dn(animation);
      ani_upd = 1'b1;
    end

    if (!auto_en) begin
      state_nx = MODE_MANUAL;
      loop_nx  = '0;
    end else begin
      unique case (state)
        MODE_MANUAL: begin
          state_nx = MODE_AUTO;
          loop_nx  = '0;
        end
        MODE_AUTO: begin
          // a manual step in the wrap cycle suppresses the auto advance
          if (manual) begin
            state_nx = MODE_HOLD;
            loop_nx  = '0;
          end else if (digit_wrap) begin
            if (loop_cnt == LOOP_BIT'(LOOPS_PER_ANI - 1)) begin
              ani_nx  = ani_up(animation);
              ani_upd = 1'b1;
              loop_nx = '0;
            end else begin
              loop_nx = loop_cnt + 1'b1;
            end
          end
        end
        MODE_HOLD: begin
          if (manual) begin
            loop_nx = '0;
          end else if (digit_wrap) begin
            if (loop_cnt == LOOP_BIT'(HOLD_LOOPS - 1)) begin
              state_nx = MODE_AUTO;
              loop_nx  = '0;
            end else begin
              loop_nx = loop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nx = MODE_MANUAL;
          loop_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= MODE_MANUAL;
      loop_cnt   <= '0;
      animation  <= '0;
      compare    <= COM_RST;
      ani_change <= 1'b0;
    end else begin
      state      <= state_nx;
      loop_cnt   <= loop_nx;
      animation  <= ani_nx;
      compare    <= spd_next(compare, spd_inc_s, spd_dec_s);
      ani_change <= ani_upd;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_ani_scheduler.sv
// Directed bench for ani_scheduler with a cycle-level reference model and literal spot checks.
module tb_ani_scheduler;

  localparam int R = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_ani_inc = 0, req_ani_dec = 0, req_spd_inc = 0, req_spd_dec = 0;
  logic        auto_en = 0, digit_wrap = 0;
  logic [5:0]  animation;
  logic [24:0] compare;
  logic        ani_change;
  logic [1:0]  mode;

  int n_vec = 0;
  int n_err = 0;

`ifdef ANI_SCHED_REPEAT_EN
  ani_scheduler #(.REPEAT_CYCLES(R)) dut (
`else
  ani_scheduler dut (
`endif
    .clk(clk), .reset(reset),
    .req_ani_inc(req_ani_inc), .req_ani_dec(req_ani_dec),
    .req_spd_inc(req_spd_inc), .req_spd_dec(req_spd_dec),
    .auto_en(auto_en), .digit_wrap(digit_wrap),
    .animation(animation), .compare(compare), .ani_change(ani_change), .mode(mode)
  );

  always #50 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer bookkeeping of the behaviour rules
  int m_ani = 0, m_cmp = 10_000_000, m_mode = 0, m_loops = 0, m_chg = 0;
  int p_ai = 0, p_ad = 0, p_si = 0, p_sd = 0;
  int t_si = 0, t_sd = 0;

  task automatic model_step();
    int ri, rd, si, sd, na, upd;
    if (reset) begin
      m_ani = 0; m_cmp = 10_000_000; m_mode = 0; m_loops = 0; m_chg = 0;
      p_ai = 0; p_ad = 0; p_si = 0; p_sd = 0; t_si = 0; t_sd = 0;
      return;
    end
    ri = req_ani_inc && !p_ai;
    rd = req_ani_dec && !p_ad;
    si = req_spd_inc && !p_si;
    sd = req_spd_dec && !p_sd;
`ifdef ANI_SCHED_REPEAT_EN
    if (req_spd_inc) begin
      if (si) t_si = 0; else t_si++;
      if (!si && t_si > 0 && t_si % R == 0) si = 1;
    end else t_si = 0;
    if (req_spd_dec) begin
      if (sd) t_sd = 0; else t_sd++;
      if (!sd && t_sd > 0 && t_sd % R == 0) sd = 1;
    end else t_sd = 0;
`endif
    na = m_ani; upd = 0;
    if (ri) begin na = (m_ani + 1) % 64; upd = 1; end
    else if (rd) begin na = (m_ani + 63) % 64; upd = 1; end
    if (si) begin
      if (m_cmp + 1_000_000 <= 20_000_000) m_cmp += 1_000_000;
    end else if (sd) begin
      if (m_cmp - 1_000_000 >= 1_000_000) m_cmp -= 1_000_000;
    end
    if (!auto_en) begin
      m_mode = 0; m_loops = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_loops = 0;
    end else if (m_mode == 1) begin
      if (ri || rd) begin m_mode = 2; m_loops = 0; end
      else if (digit_wrap) begin
        m_loops++;
        if (m_loops == 4) begin na = (m_ani + 1) % 64; upd = 1; m_loops = 0; end
      end
    end else begin
      if (ri || rd) m_loops = 0;
      else if (digit_wrap) begin
        m_loops++;
        if (m_loops == 8) begin m_mode = 1; m_loops = 0; end
      end
    end
    m_ani = na; m_chg = upd;
    p_ai = req_ani_inc; p_ad = req_ani_dec; p_si = req_spd_inc; p_sd = req_spd_dec;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("model.animation", animation, m_ani);
      chk("model.compare", compare, m_cmp);
      chk("model.ani_change", ani_change, m_chg);
      chk("model.mode", mode, m_mode);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_wrap(input int n);
    repeat (n) begin
      digit_wrap = 1; tick(1);
      digit_wrap = 0; tick(1);
    end
  endtask

  task automatic press(input int which, input int n);
    repeat (n) begin
      case (which)
        0: req_ani_inc = 1;
        1: req_ani_dec = 1;
        2: req_spd_inc = 1;
        default: req_spd_dec = 1;
      endcase
      tick(1);
      req_ani_inc = 0; req_ani_dec = 0; req_spd_inc = 0; req_spd_dec = 0;
      tick(1);
    end
  endtask

  int cmp_after_hold;

  initial begin
    tick(3);
    chk("reset.animation", animation, 0);
    chk("reset.compare", compare, 10_000_000);
    chk("reset.mode", mode, 0);
    chk("reset.ani_change", ani_change, 0);
    reset = 0;
    tick(2);

    // held inc level steps exactly once
    req_ani_inc = 1; tick(1);
    chk("hold.first_step", animation, 1);
    chk("hold.change_pulse", ani_change, 1);
    tick(1);
    chk("hold.change_clear", ani_change, 0);
    tick(998);
    chk("hold.no_repeat", animation, 1);
    req_ani_inc = 0; tick(2);
    press(1, 1);
    chk("dec.to_zero", animation, 0);
    press(1, 1);
    chk("dec.wrap", animation, 63);

    // speed saturation and simultaneous requests
    press(2, 10);
    chk("spd.at_max", compare, 20_000_000);
    press(2, 1);
    chk("spd.sat_max", compare, 20_000_000);
    press(3, 19);
    chk("spd.at_min", compare, 1_000_000);
    press(3, 1);
    chk("spd.sat_min", compare, 1_000_000);
    press(2, 9);
    req_spd_inc = 1; req_spd_dec = 1; tick(1);
    req_spd_inc = 0; req_spd_dec = 0; tick(1);
    chk("spd.both", compare, 11_000_000);

    // long speed hold from 10 M
    press(3, 1);
    req_spd_inc = 1; tick(3 * R);
    req_spd_inc = 0; tick(1);
`ifdef ANI_SCHED_REPEAT_EN
    cmp_after_hold = 13_000_000;
`else
    cmp_after_hold = 11_000_000;
`endif
    chk("spd.hold", compare, cmp_after_hold);

    // auto mode
    auto_en = 1; tick(1);
    chk("auto.enter", mode, 1);
    pulse_wrap(3);
    chk("auto.no_adv_yet", animation, 63);
    pulse_wrap(1);
    chk("auto.adv_wrap", animation, 0);
    pulse_wrap(3);
    req_ani_inc = 1; digit_wrap = 1; tick(1);
    req_ani_inc = 0; digit_wrap = 0;
    chk("auto.manual_wins", animation, 1);
    chk("auto.to_hold", mode, 2);
    tick(1);

    // hold countdown and auto_en drop
    pulse_wrap(7);
    chk("hold.still", mode, 2);
    pulse_wrap(1);
    chk("hold.to_auto", mode, 1);
    press(0, 1);
    chk("hold.reenter", mode, 2);
    pulse_wrap(3);
    auto_en = 0; tick(1);
    chk("manual.exit", mode, 0);
    pulse_wrap(10);
    chk("manual.no_adv", animation, 2);

    // reset mid-AUTO
    auto_en = 1; tick(1);
    press(0, 3);
    pulse_wrap(8);
    press(2, (13_000_000 - cmp_after_hold) / 1_000_000);
    chk("pre_reset.mode", mode, 1);
    chk("pre_reset.animation", animation, 5);
    chk("pre_reset.compare", compare, 13_000_000);
    #20 reset = 1;
    #1;
    chk("async.animation", animation, 0);
    chk("async.compare", compare, 10_000_000);
    chk("async.mode", mode, 0);
    tick(2);
    reset = 0; auto_en = 0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
